// File: rtl/whack_game_ctrl_if.sv
// Player-input bus for the whack game controller: start button level and whack attempts.
interface whack_game_ctrl_if #(
  parameter int IDX_W = 3
);
  logic             start_game;
  logic             hit_valid;
  logic [IDX_W-1:0] hit_idx;

  modport master (output start_game, hit_valid, hit_idx);
  modport slave  (input  start_game, hit_valid, hit_idx);
endinterface

// File: rtl/whack_game_ctrl.sv
// Whack-an-engineer game sequencer: spawns moles, times windows, scores hits, counts misses.
// Optional build macro WRONG_HIT_PENALTY_EN: a wrong-index whack counts as a miss.
module whack_game_ctrl #(
  parameter int          NUM_MOLES     = 8,
  parameter int          IDX_W         = 3,
  parameter int          SCORE_W       = 8,
  parameter int          MISS_LIMIT    = 5,
  parameter int          WINDOW_CYCLES = 100,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                 clock,
  input  logic                 reset,
  whack_game_ctrl_if.slave     bus,
  output logic [2:0]           state,
  output logic [NUM_MOLES-1:0] mole_up,
  output logic [SCORE_W-1:0]   score,
  output logic [7:0]           misses,
  output logic                 game_over,
  output logic                 hit_ok,
  output logic                 miss
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_SPAWN  = 3'd2,
    S_ACTIVE = 3'd3,
    S_OVER   = 3'd4
  } state_t;

  localparam int                CNT_W    = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(WINDOW_CYCLES - 1);
  localparam logic [IDX_W:0]    NM       = (IDX_W + 1)'(NUM_MOLES);
  localparam logic [7:0]        LIMIT    = 8'(MISS_LIMIT);

  state_t               st_q, st_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [SCORE_W-1:0]   score_d;
  logic [7:0]           misses_d, misses_inc;
  logic [NUM_MOLES-1:0] mole_dec;
  logic                 hit_ok_d, miss_d, take_miss;
  logic                 hit_good, hit_bad;
  logic [IDX_W:0]       raw, wrap;
  logic [IDX_W-1:0]     cand;

  // Galois form, taps 16,14,13,11
  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  // Fold the random index into range, then step past a repeat of the last mole
  always_comb begin
    raw  = {1'b0, lfsr_q[IDX_W-1:0]};
    if (raw >= NM) raw = raw - NM;
    wrap = '0;
    cand = raw[IDX_W-1:0];
    if (cand == idx_q) begin
      wrap = {1'b0, cand} + 1'b1;
      if (wrap == NM) wrap = '0;
      cand = wrap[IDX_W-1:0];
    end
  end

  assign hit_good   = bus.hit_valid && (bus.hit_idx == idx_q);
  assign hit_bad    = bus.hit_valid && !hit_good;
  assign misses_inc = misses + 8'd1;

  always_comb begin
    st_d      = st_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    score_d   = score;
    misses_d  = misses;
    hit_ok_d  = 1'b0;
    miss_d    = 1'b0;
    take_miss = 1'b0;
    case (st_q)
      S_IDLE:  st_d = S_START;
      S_START: begin
        if (bus.start_game) begin
          st_d     = S_SPAWN;
          score_d  = '0;
          misses_d = '0;
        end
      end
      S_SPAWN: begin
        idx_d = cand;
        cnt_d = CNT_LOAD;
        st_d  = S_ACTIVE;
      end
      S_ACTIVE: begin
        cnt_d = cnt_q - 1'b1;
        if (hit_good) begin
          score_d  = (&score) ? score : score + 1'b1;
          hit_ok_d = 1'b1;
          st_d     = S_SPAWN;
        end else if (cnt_q == '0) begin
          take_miss = 1'b1;
        end
`ifdef WRONG_HIT_PENALTY_EN
        else if (hit_bad) begin
          take_miss = 1'b1;
        end
`endif
        if (take_miss) begin
          miss_d   = 1'b1;
          misses_d = misses_inc;
          st_d     = (misses_inc == LIMIT) ? S_OVER : S_SPAWN;
        end
      end
      S_OVER: begin
        if (bus.start_game) st_d = S_START;
      end
      default: st_d = S_IDLE;
    endcase
  end

  // Mole outputs are registered from the next-state view so they line up with state
  for (genvar i = 0; i < NUM_MOLES; i++) begin : g_dec
    assign mole_dec[i] = (st_d == S_ACTIVE) && (idx_d == IDX_W'(i));
  end

`ifndef WRONG_HIT_PENALTY_EN
  logic unused_bad;
  assign unused_bad = hit_bad;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st_q      <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      lfsr_q    <= LFSR_SEED;
      score     <= '0;
      misses    <= '0;
      mole_up   <= '0;
      game_over <= 1'b0;
      hit_ok    <= 1'b0;
      miss      <= 1'b0;
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      lfsr_q    <= lfsr_d;
      score     <= score_d;
      misses    <= misses_d;
      mole_up   <= mole_dec;
      game_over <= (st_d == S_OVER);
      hit_ok    <= hit_ok_d;
      miss      <= miss_d;
    end
  end

  assign state = st_q;

endmodule

// File: tb/tb_whack_game_ctrl.sv
// Scoreboard bench for whack_game_ctrl: stimulus queues expected pulses, a monitor checks them.
module tb_whack_game_ctrl;
  localparam int NUM_MOLES = 8, IDX_W = 3, SCORE_W = 2, MISS_LIMIT = 5, WINDOW_CYCLES = 4;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [2:0]           state;
  logic [NUM_MOLES-1:0] mole_up;
  logic [SCORE_W-1:0]   score;
  logic [7:0]           misses;
  logic                 game_over, hit_ok, miss;

  whack_game_ctrl_if #(.IDX_W(IDX_W)) bus();

  whack_game_ctrl #(
    .NUM_MOLES(NUM_MOLES), .IDX_W(IDX_W), .SCORE_W(SCORE_W),
    .MISS_LIMIT(MISS_LIMIT), .WINDOW_CYCLES(WINDOW_CYCLES), .LFSR_SEED(16'hACE1)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus), .state(state), .mole_up(mole_up),
    .score(score), .misses(misses), .game_over(game_over), .hit_ok(hit_ok), .miss(miss)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    bit          is_hit;
    int unsigned cyc;
    int          score;
    int          misses;
    int          state;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   pass_cnt = 0;
  int   total    = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every pulse must match the oldest queued expectation
  always @(negedge clock) begin
    if (!reset && (hit_ok || miss)) begin
      if (q.size() == 0) chk("unexpected_pulse", {30'd0, hit_ok, miss}, 0);
      else begin
        e = q.pop_front();
        chk("pulse_kind",    {30'd0, hit_ok, miss}, e.is_hit ? 2 : 1);
        chk("pulse_cycle",   int'(cyc), int'(e.cyc));
        chk("pulse_score",   int'(score), e.score);
        chk("pulse_misses",  int'(misses), e.misses);
        chk("pulse_state",   int'(state), e.state);
        chk("pulse_mole_up", int'(mole_up), 0);
      end
    end
  end

  function automatic int onehot_idx(input logic [NUM_MOLES-1:0] v);
    for (int i = 0; i < NUM_MOLES; i++) if (v[i]) return i;
    return -1;
  endfunction

  int prev_idx, cur_idx, exp_misses;
  logic [NUM_MOLES-1:0] saved_up;

  task automatic wait_active(input string name);
    for (int i = 0; i < 20; i++) begin
      if (state == 3'd3) return;
      @(negedge clock);
    end
    chk(name, int'(state), 3);
  endtask

  // Whack the currently lit mole; leaves us at the negedge of the SPAWN cycle
  task automatic do_hit(input int exp_score, input int exp_misses_v);
    int idx;
    idx = onehot_idx(mole_up);
    chk("hit_onehot", $countones(mole_up), 1);
    bus.hit_valid = 1'b1;
    bus.hit_idx   = IDX_W'(idx);
    q.push_back('{1'b1, cyc + 1, exp_score, exp_misses_v, 2});
    @(negedge clock);
    bus.hit_valid = 1'b0;
    prev_idx = idx;
  endtask

  task automatic check_new_mole(input string name);
    @(negedge clock);
    chk({name, "_state"}, int'(state), 3);
    cur_idx = onehot_idx(mole_up);
    chk({name, "_differs"}, int'(cur_idx != prev_idx && cur_idx >= 0), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.start_game = 1'b0;
    bus.hit_valid  = 1'b0;
    bus.hit_idx    = '0;
    exp_misses     = 0;
    repeat (2) @(negedge clock);
    chk("rst_state",     int'(state), 0);
    chk("rst_mole_up",   int'(mole_up), 0);
    chk("rst_score",     int'(score), 0);
    chk("rst_misses",    int'(misses), 0);
    chk("rst_game_over", int'(game_over), 0);
    chk("rst_pulses",    int'({hit_ok, miss}), 0);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_to_start", int'(state), 1);
    repeat (3) @(negedge clock);
    chk("start_holds",   int'(state), 1);
    chk("start_no_mole", int'(mole_up), 0);

    bus.start_game = 1'b1;
    @(negedge clock);
    chk("spawn_state", int'(state), 2);
    bus.start_game = 1'b0;
    @(negedge clock);
    chk("first_active", int'(state), 3);
    cur_idx = onehot_idx(mole_up);
    chk("first_not_mole0", int'(cur_idx > 0), 1);

    do_hit(1, 0);
    check_new_mole("after_hit1");

    // Correct hit on the counter==0 cycle still counts as a hit
    repeat (WINDOW_CYCLES - 1) @(negedge clock);
    chk("last_cycle_active", int'(state), 3);
    do_hit(2, 0);
    check_new_mole("after_boundary");

    for (int k = 0; k < 3; k++) begin
      do_hit(3, 0);
      check_new_mole("sat_hit");
    end
    chk("score_saturated", int'(score), 3);

    // Wrong whack on the first cycle of a window
    saved_up = mole_up;
    cur_idx  = onehot_idx(mole_up);
    bus.hit_valid = 1'b1;
    bus.hit_idx   = IDX_W'((cur_idx + 1) % NUM_MOLES);
`ifdef WRONG_HIT_PENALTY_EN
    exp_misses = 1;
    q.push_back('{1'b0, cyc + 1, 3, 1, 2});
    @(negedge clock);
    bus.hit_valid = 1'b0;
    chk("wrong_spawn", int'(state), 2);
`else
    @(negedge clock);
    bus.hit_valid = 1'b0;
    chk("wrong_mole_kept",  int'(mole_up), int'(saved_up));
    chk("wrong_still_act",  int'(state), 3);
    do_hit(3, 0);
`endif

    for (int k = 0; k < 6 && exp_misses < MISS_LIMIT; k++) begin
      wait_active("timeout_active");
      exp_misses++;
      q.push_back('{1'b0, cyc + WINDOW_CYCLES, 3, exp_misses,
                    (exp_misses == MISS_LIMIT) ? 4 : 2});
      repeat (WINDOW_CYCLES) @(negedge clock);
    end
    chk("over_state",     int'(state), 4);
    chk("over_flag",      int'(game_over), 1);
    chk("over_misses",    int'(misses), MISS_LIMIT);
    chk("over_mole_up",   int'(mole_up), 0);
    @(negedge clock);
    chk("over_held",      int'(state), 4);
    chk("over_score_kept", int'(score), 3);

    bus.start_game = 1'b1;
    @(negedge clock);
    chk("restart_start", int'(state), 1);
    @(negedge clock);
    chk("restart_spawn",  int'(state), 2);
    chk("restart_score",  int'(score), 0);
    chk("restart_misses", int'(misses), 0);
    chk("restart_go",     int'(game_over), 0);
    bus.start_game = 1'b0;
    @(negedge clock);
    chk("restart_active", int'(state), 3);
    do_hit(1, 0);
    check_new_mole("pre_reset");

    // Asynchronous reset in the middle of a window
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_state",   int'(state), 0);
    chk("mid_rst_mole_up", int'(mole_up), 0);
    chk("mid_rst_score",   int'(score), 0);
    chk("mid_rst_misses",  int'(misses), 0);
    chk("mid_rst_pulses",  int'({game_over, hit_ok, miss}), 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("queue_drained", q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/whack_game_ctrl.md
# whack_game_ctrl

Parametrised top-level game controller for the whack-an-engineer game. It sequences idle, start screen, play and game-over, and spawns one mole at a time at a pseudo-random position. It times each mole's up-window, scores correct whacks, counts misses, and ends the game at a configurable miss limit. It sits between the input-decoding front end (start button, whack index) and the display/score rendering logic.

## Interface
- NUM_MOLES, 8, number of mole positions; must satisfy 2^(IDX_W-1) < NUM_MOLES <= 2^IDX_W
- IDX_W, 3, width of a mole index
- SCORE_W, 8, score counter width
- MISS_LIMIT, 5, misses that end the game (1..255)
- WINDOW_CYCLES, 100, cycles a mole stays up (>= 2)
- LFSR_SEED, 16'hACE1, nonzero LFSR reset value
---
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- start_game  in  1  level; sampled each cycle
- hit_valid  in  1  one whack attempt this cycle
- hit_idx  in  IDX_W  position whacked (valid with hit_valid)
- state  out  3  current FSM state encoding
- mole_up  out  NUM_MOLES  one-hot active mole; all-zero outside ACTIVE
- score  out  SCORE_W  correct whacks, saturating
- misses  out  8  misses this game
- game_over  out  1  high while in GAMEOVER
- hit_ok  out  1  one-cycle pulse per correct whack
- miss  out  1  one-cycle pulse per miss

## Operation
- States: IDLE=0, START_SCREEN=1, SPAWN=2, ACTIVE=3, GAMEOVER=4; undefined codes go to IDLE.
- IDLE -> START_SCREEN unconditionally on the next cycle.
- START_SCREEN -> SPAWN when start_game=1. Score and misses clear on this transition.
- SPAWN (one cycle) chooses the next mole:
  - cand = lfsr[IDX_W-1:0]; if cand >= NUM_MOLES, cand -= NUM_MOLES.
  - If cand == the previous mole, cand = (cand+1) mod NUM_MOLES.
  - Latch cand as the active index, load the window counter with WINDOW_CYCLES-1, go to ACTIVE.
- ACTIVE: mole_up = 1 << active index; the counter decrements each cycle.
  - hit_valid && hit_idx == active index: score += 1 (saturates at 2^SCORE_W-1), hit_ok pulse, -> SPAWN.
  - Counter == 0 with no correct hit: miss pulse, misses += 1.
    - If the new misses value == MISS_LIMIT, -> GAMEOVER.
    - Otherwise -> SPAWN.
  - A correct hit in the counter==0 cycle counts as a hit; no miss is recorded.
  - hit_valid with the wrong index: see Configuration.
  - hit_idx >= NUM_MOLES is always treated as a wrong index.
- GAMEOVER: game_over=1, mole_up=0, score and misses held.
  - start_game=1 -> START_SCREEN.
  - Holding start_game high therefore restarts play two cycles later.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1. It advances every cycle in every state, so spawn order depends on player timing.
- Previous-mole register resets to 0, so the first spawn after reset cannot be mole 0.

## Timing
- All outputs are registered.
- Reset values: state=IDLE, mole_up=0, score=0, misses=0, game_over=0, hit_ok=0, miss=0, lfsr=LFSR_SEED, previous mole=0.
- Reset asserted mid-game returns to IDLE immediately (asynchronously). No pulse is emitted.
- ACTIVE lasts exactly WINDOW_CYCLES cycles if no hit occurs.
- Correct hit in ACTIVE cycle N:
  - cycle N+1: hit_ok=1, score updated, state=SPAWN, mole_up=0.
  - cycle N+2: new mole up.
- Timeout: miss=1 and misses updated in the cycle after the counter==0 cycle, together with the SPAWN or GAMEOVER state.
- Mole-to-mole gap is exactly one cycle (SPAWN).

## Configuration
- WRONG_HIT_PENALTY_EN defined: a wrong-index hit_valid in ACTIVE counts as a miss. It pulses miss, increments misses, applies the MISS_LIMIT check, and goes to SPAWN or GAMEOVER; the current mole is abandoned.
- WRONG_HIT_PENALTY_EN undefined: wrong-index whacks are ignored. The mole stays up and the counter continues.

## Test plan
- Reset, idle: reset pulse -> state=0 then 1 next cycle; all counters 0; mole_up=0; no spawn without start_game.
- Correct hit: start_game; on the first ACTIVE cycle drive hit_valid with the index of the set bit in mole_up -> hit_ok 1 cycle, score=1, SPAWN, a new different mole two cycles after the hit.
- Timeout to game over (MISS_LIMIT=5, WINDOW_CYCLES=4): never hit -> miss pulse every 5 cycles (4 ACTIVE + 1 SPAWN); after the 5th miss state=4, game_over=1, misses=5, mole_up=0.
- Boundary hit: correct hit exactly on the last ACTIVE cycle -> hit_ok=1, miss=0, misses unchanged.
- Wrong whack: hit a non-active index -> macro off: no pulse, mole still up; macro on: miss=1, misses+1, new SPAWN.
- Saturation and restart (SCORE_W=2): 5 correct hits -> score stays 3. In GAMEOVER, start_game -> START_SCREEN -> SPAWN with score=0, misses=0. Reset asserted during ACTIVE -> IDLE with all outputs at reset values.
